// File: rtl/multi_walk_register.sv
// Multi-channel walk request register: latches button edges, grants pending channels round-robin.
// Optional 2-flop input synchroniser enabled by defining MULTI_WALK_REGISTER_SYNC_EN.
module multi_walk_register #(
   parameter int N_CH     = 4,
   parameter int MAX_WAIT = 200,
   parameter int CNT_W    = 8
) (
   input  logic                    clk,
   input  logic                    global_reset_n,
   input  logic [N_CH-1:0]         walk_request,
   input  logic                    walk_request_reset,
   output logic                    wr_to_fsm,
   output logic [$clog2(N_CH)-1:0] wr_ch,
   output logic [N_CH-1:0]         wr_pending,
   output logic                    wr_urgent,
   output logic [CNT_W-1:0]        wr_served_cnt
);

   localparam int CH_W   = $clog2(N_CH);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t            state_q;
   logic [N_CH-1:0]   req_s;
   logic [N_CH-1:0]   prev_q;
   logic [N_CH-1:0]   pending_q, pending_d;
   logic [N_CH-1:0]   rise, clr;
   logic [CH_W-1:0]   ch_q, last_q, sel;
   logic              to_fsm_q;
   logic [WAIT_W-1:0] wait_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ack;

`ifdef MULTI_WALK_REGISTER_SYNC_EN
   logic [N_CH-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= walk_request;
         sync2_q <= sync1_q;
      end
   end

   assign req_s = sync2_q;
`else
   assign req_s = walk_request;
`endif

   assign ack  = (state_q == GRANT) && walk_request_reset;
   assign rise = req_s & ~prev_q;

   // A fresh edge on the channel being acknowledged re-arms it: set beats clear.
   always_comb begin
      clr = '0;
      if (ack) clr[ch_q] = 1'b1;
      pending_d = (pending_q & ~clr) | rise;
   end

   // Round-robin pick: first pending bit strictly after the last serviced channel.
   always_comb begin
      int  idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = (int'(last_q) + 1 + k) % N_CH;
         if (!found && pending_q[idx]) begin
            found = 1'b1;
            sel   = CH_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         prev_q    <= '0;
         pending_q <= '0;
      end else begin
         prev_q    <= req_s;
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state_q  <= IDLE;
         ch_q     <= '0;
         last_q   <= CH_W'(N_CH - 1);
         to_fsm_q <= 1'b0;
         wait_q   <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|pending_q) begin
                  ch_q     <= sel;
                  to_fsm_q <= 1'b1;
                  wait_q   <= '0;
                  state_q  <= GRANT;
               end
            end
            GRANT: begin
               if (walk_request_reset) begin
                  last_q   <= ch_q;
                  cnt_q    <= cnt_q + 1'b1;
                  to_fsm_q <= 1'b0;
                  wait_q   <= '0;
                  state_q  <= RELEASE;
               end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            RELEASE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wr_to_fsm     = to_fsm_q;
   assign wr_ch         = ch_q;
   assign wr_pending    = pending_q;
   assign wr_urgent     = (wait_q == WAIT_W'(MAX_WAIT));
   assign wr_served_cnt = cnt_q;

endmodule
